tdc_meas_sequencer: RTL and testbench

//  Sequences one start/stop time measurement around the START/STOP edge detectors.

---
 rtl/tdc_meas_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_tdc_meas_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_sequencer.sv
// rtl/tdc_meas_sequencer.sv - start/stop time measurement sequencer with hit FIFO
module tdc_meas_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_HITS = 4,
  parameter int TIMEOUT  = 1000,
  parameter int HIT_W    = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             start_edge_i,
  input  logic             stop_edge_i,
  output logic             det_arm_o,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_data_o,
  output logic [HIT_W-1:0] res_idx_o,
  output logic             res_last_o,
  output logic             done_o,
  output logic [HIT_W:0]   hit_count_o,
  output logic             timeout_flag_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_RUN_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [HIT_W:0]   LAST_HIT_CNT = (HIT_W+1)'(MAX_HITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] coarse_q, coarse_d;
  logic [HIT_W:0]   hit_count_q, hit_count_d;
  logic             timeout_flag_q, timeout_flag_d;

  logic [CNT_W-1:0] fifo_data_q [MAX_HITS];
  logic [HIT_W-1:0] fifo_idx_q  [MAX_HITS];
  logic [HIT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [HIT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [HIT_W:0]   count_q, count_d;

  logic fifo_empty;
  logic push;
  logic pop;
  logic timeout_hit;
  logic last_hit;

  // Abort overrides every event, so it masks both push and pop
  assign fifo_empty  = (count_q == '0);
  assign push        = (state_q == S_RUN) && stop_edge_i && !abort_i;
  assign pop         = !fifo_empty && res_ready_i && !abort_i;
  assign timeout_hit = (state_q == S_RUN) && (coarse_q == LAST_RUN_CNT);
  assign last_hit    = push && (hit_count_q == LAST_HIT_CNT);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arm_i && !abort_i) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (abort_i)           state_d = S_IDLE;
        else if (start_edge_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort_i)                     state_d = S_IDLE;
        else if (last_hit || timeout_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_i || fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; done marks the DRAIN->IDLE cycle itself
  always_comb begin
    det_arm_o = (state_q == S_ARMED) || (state_q == S_RUN);
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DRAIN) && fifo_empty && !abort_i;
  end

  // Measurement bookkeeping: coarse timer, hit counter, timeout flag
  always_comb begin
    coarse_d       = coarse_q;
    hit_count_d    = hit_count_q;
    timeout_flag_d = timeout_flag_q;
    if (state_q == S_IDLE && arm_i && !abort_i) begin
      hit_count_d    = '0;
      timeout_flag_d = 1'b0;
    end
    if (state_q == S_ARMED && start_edge_i && !abort_i) begin
      coarse_d = '0;
    end
    if (state_q == S_RUN) begin
      coarse_d = coarse_q + CNT_W'(1);
    end
    if (push) begin
      hit_count_d = hit_count_q + (HIT_W+1)'(1);
    end
    // Filling the last slot wins over a coincident timeout
    if (timeout_hit && !abort_i && !last_hit) begin
      timeout_flag_d = 1'b1;
    end
  end

  // Bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      coarse_q       <= '0;
      hit_count_q    <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      coarse_q       <= coarse_d;
      hit_count_q    <= hit_count_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  // FIFO pointer/occupancy next state; abort empties the queue
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + HIT_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + HIT_W'(1);
      if (push && !pop)      count_d = count_q + (HIT_W+1)'(1);
      else if (pop && !push) count_d = count_q - (HIT_W+1)'(1);
    end
  end

  // FIFO pointer registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= coarse_q;
      fifo_idx_q[wr_ptr_q]  <= hit_count_q[HIT_W-1:0];
    end
  end

  // Result port; payload forced to zero while empty so reset shows all-zero outputs
  always_comb begin
    res_valid_o    = !fifo_empty;
    res_data_o     = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    res_idx_o      = fifo_empty ? '0 : fifo_idx_q[rd_ptr_q];
    res_last_o     = !fifo_empty
                     && (state_q == S_DRAIN || state_q == S_IDLE)
                     && (({1'b0, fifo_idx_q[rd_ptr_q]} + (HIT_W+1)'(1)) == hit_count_q);
    hit_count_o    = hit_count_q;
    timeout_flag_o = timeout_flag_q;
  end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// tb/tb_tdc_meas_sequencer.sv - table-driven and scoreboard bench for tdc_meas_sequencer
module tb_tdc_meas_sequencer;

  localparam int CNT_W    = 16;
  localparam int MAX_HITS = 4;
  localparam int TIMEOUT  = 1000;
  localparam int HIT_W    = 2;

  typedef struct {
    int n;
    int stops[4];
    bit stray;
    bit retrig;
    int exp_hc;
    bit exp_tf;
  } vec_t;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             arm_i;
  logic             abort_i;
  logic             start_edge_i;
  logic             stop_edge_i;
  logic             det_arm_o;
  logic             busy_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [CNT_W-1:0] res_data_o;
  logic [HIT_W-1:0] res_idx_o;
  logic             res_last_o;
  logic             done_o;
  logic [HIT_W:0]   hit_count_o;
  logic             timeout_flag_o;

  int   checks = 0;
  int   errors = 0;
  int   beats = 0;
  int   done_cnt = 0;
  exp_t sbq[$];
  vec_t vecs[7];

  tdc_meas_sequencer #(
    .CNT_W(CNT_W), .MAX_HITS(MAX_HITS), .TIMEOUT(TIMEOUT), .HIT_W(HIT_W)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .arm_i(arm_i),
    .abort_i(abort_i),
    .start_edge_i(start_edge_i),
    .stop_edge_i(stop_edge_i),
    .det_arm_o(det_arm_o),
    .busy_o(busy_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o(res_data_o),
    .res_idx_o(res_idx_o),
    .res_last_o(res_last_o),
    .done_o(done_o),
    .hit_count_o(hit_count_o),
    .timeout_flag_o(timeout_flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t mk(input int n, input int s0, input int s1, input int s2, input int s3,
                              input bit stray, input bit retrig, input int hc, input bit tf);
    vec_t v;
    v.n = n;
    v.stops[0] = s0; v.stops[1] = s1; v.stops[2] = s2; v.stops[3] = s3;
    v.stray = stray; v.retrig = retrig; v.exp_hc = hc; v.exp_tf = tf;
    return v;
  endfunction

  // Handshake monitor: pops the scoreboard on every accepted beat, counts done pulses
  always @(negedge clk) begin
    if (!reset_i) begin
      if (res_valid_o && res_ready_i) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got data %0d idx %0d expected no beat", res_data_o, res_idx_o);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("beat_data", 32'(res_data_o), e.data);
          chk("beat_idx", 32'(res_idx_o), e.idx);
          chk("beat_last", 32'(res_last_o), 32'(e.last));
          beats++;
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic arm_and_start(input bit stray);
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
    chk("armed_det_arm", 32'(det_arm_o), 1);
    chk("armed_busy", 32'(busy_o), 1);
    chk("armed_hit_count", 32'(hit_count_o), 0);
    chk("armed_timeout_flag", 32'(timeout_flag_o), 0);
    if (stray) begin
      stop_edge_i = 1'b1;
      cyc();
      stop_edge_i = 1'b0;
      chk("armed_stray_stop_hold", 32'(det_arm_o), 1);
      chk("armed_stray_no_push", 32'(res_valid_o), 0);
    end
    start_edge_i = 1'b1;
    cyc();
    start_edge_i = 1'b0;
    chk("run_det_arm", 32'(det_arm_o), 1);
  endtask

  task automatic run_meas(input vec_t v);
    int k;
    bit ex;
    bit pushed;
    exp_t e;
    k = 0;
    beats = 0;
    done_cnt = 0;
    arm_and_start(v.stray);
    for (int c = 0; c < TIMEOUT; c++) begin
      ex = 0;
      pushed = 0;
      if (k < v.n && v.stops[k] == c) begin
        stop_edge_i = 1'b1;
        e.data = c;
        e.idx = k;
        e.last = (k == v.n - 1);
        sbq.push_back(e);
        k++;
        pushed = 1;
        if (k == MAX_HITS) ex = 1;
      end
      if (v.retrig && c == 3) start_edge_i = 1'b1;
      if (c == TIMEOUT - 1) ex = 1;
      cyc();
      stop_edge_i = 1'b0;
      start_edge_i = 1'b0;
      if (pushed && k == 1) chk("hit_latency", 32'(res_valid_o), 1);
      if (ex) break;
    end
    chk("drain_busy", 32'(busy_o), 1);
    chk("drain_det_arm", 32'(det_arm_o), 0);
    chk("drain_hit_count", 32'(hit_count_o), v.exp_hc);
    chk("drain_timeout_flag", 32'(timeout_flag_o), 32'(v.exp_tf));
    chk("drain_res_valid", 32'(res_valid_o), 32'(v.n > 0));
    res_ready_i = 1'b1;
    for (int w = 0; w < 40 && busy_o; w++) cyc();
    res_ready_i = 1'b0;
    chk("drain_reaches_idle", 32'(busy_o), 0);
    chk("done_once", done_cnt, 1);
    chk("beats_total", beats, v.n);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("idle_res_valid", 32'(res_valid_o), 0);
    chk("idle_hit_count", 32'(hit_count_o), v.exp_hc);
    chk("idle_timeout_sticky", 32'(timeout_flag_o), 32'(v.exp_tf));
    sbq.delete();
  endtask

  initial begin
    reset_i = 1'b1;
    arm_i = 1'b0;
    abort_i = 1'b0;
    start_edge_i = 1'b0;
    stop_edge_i = 1'b0;
    res_ready_i = 1'b0;

    //            n  stops               stray retrig hc tf
    vecs[0] = mk(2,   5,  17,   0,   0,  0,    0,     2, 1);
    vecs[1] = mk(4,   1,   2,   3,   4,  0,    0,     4, 0);
    vecs[2] = mk(4,   0,   1,   2,   3,  0,    0,     4, 0);
    vecs[3] = mk(2,   6,   9,   0,   0,  1,    1,     2, 1);
    vecs[4] = mk(1, 999,   0,   0,   0,  0,    0,     1, 1);
    vecs[5] = mk(4,  10,  20,  30, 999,  0,    0,     4, 0);
    vecs[6] = mk(0,   0,   0,   0,   0,  0,    0,     0, 1);

    cyc();
    cyc();
    chk("rst_det_arm", 32'(det_arm_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_res_valid", 32'(res_valid_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_hit_count", 32'(hit_count_o), 0);
    chk("rst_timeout_flag", 32'(timeout_flag_o), 0);
    reset_i = 1'b0;
    cyc();

    for (int i = 0; i < 7; i++) begin
      run_meas(vecs[i]);
      cyc();
    end

    // Abort in RUN with two hits queued
    done_cnt = 0;
    beats = 0;
    arm_and_start(1'b0);
    for (int c = 0; c < 7; c++) begin
      stop_edge_i = (c == 2 || c == 4);
      abort_i = (c == 6);
      cyc();
      stop_edge_i = 1'b0;
      abort_i = 1'b0;
    end
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_det_arm", 32'(det_arm_o), 0);
    chk("abort_res_valid", 32'(res_valid_o), 0);
    res_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    res_ready_i = 1'b0;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_beats", beats, 0);

    // Reset during DRAIN with three hits queued, arm ignored while busy
    arm_and_start(1'b0);
    for (int c = 0; c < TIMEOUT; c++) begin
      stop_edge_i = (c >= 1 && c <= 3);
      cyc();
      stop_edge_i = 1'b0;
    end
    chk("rdrain_busy", 32'(busy_o), 1);
    chk("rdrain_det_arm", 32'(det_arm_o), 0);
    chk("rdrain_head_data", 32'(res_data_o), 1);
    chk("rdrain_head_idx", 32'(res_idx_o), 0);
    chk("rdrain_head_not_last", 32'(res_last_o), 0);
    chk("rdrain_hit_count", 32'(hit_count_o), 3);
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
    chk("arm_busy_ignored", 32'(det_arm_o), 0);
    chk("arm_busy_hit_count", 32'(hit_count_o), 3);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_res_valid", 32'(res_valid_o), 0);
    chk("mid_rst_res_data", 32'(res_data_o), 0);
    chk("mid_rst_res_last", 32'(res_last_o), 0);
    chk("mid_rst_hit_count", 32'(hit_count_o), 0);
    chk("mid_rst_timeout_flag", 32'(timeout_flag_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    sbq.delete();
    cyc();
    run_meas(mk(4, 2, 4, 6, 8, 0, 0, 4, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
